sm_regfile_nr2w_sb: RTL and testbench
=====================================

Name: sm_regfile_nr2w_sb

Overview:
- Parametrised successor to the team's 2r1w register file: N combinational read ports, two write ports, optional write-to-read bypass and optional hardwired-zero entry 0.
- Adds a per-entry busy scoreboard (set on allocate, cleared on writeback), a live busy-entry counter and a sticky protocol-error flag.
- Sits in the pipelined core between decode/issue (allocate, read) and writeback (write ports).

Parameters:
- p_data_nbits, 32, data width per entry
- p_num_entries, 32, number of entries (>=2)
- p_num_rports, 2, number of read ports (>=1)
- p_reset_value, 0, value of every entry after reset
- p_zero_reg, 1, 1: entry 0 always reads 0, ignores writes, never busy
- p_bypass, 1, 1: a same-cycle write to a read address is forwarded to read data
- c_addr_nbits, $clog2(p_num_entries), local, not set externally

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- read_addr  in  p_num_rports*c_addr_nbits  packed read addresses, port k at bits [k*c_addr_nbits +: c_addr_nbits]
- read_data  out  p_num_rports*p_data_nbits  packed read data, same packing
- read_busy  out  p_num_rports  busy bit of each read address (combinational)
- write0_en  in  1  write port 0 enable
- write0_addr  in  c_addr_nbits  write port 0 address
- write0_data  in  p_data_nbits  write port 0 data
- write1_en  in  1  write port 1 enable
- write1_addr  in  c_addr_nbits  write port 1 address
- write1_data  in  p_data_nbits  write port 1 data
- alloc_en  in  1  mark alloc_addr busy
- alloc_addr  in  c_addr_nbits  entry to allocate
- num_busy  out  c_addr_nbits+1  count of busy entries
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, active-high): all entries = p_reset_value (entry 0 = 0 when p_zero_reg=1), all busy = 0, num_busy = 0, err = 0. read_data and read_busy reflect the reset state combinationally while reset is high.
- Writes are sampled on the rising edge. Each enabled write port updates its entry and clears that entry's busy bit.
- write0_addr == write1_addr with both enabled: write1 data wins, busy cleared once.
- Reads are combinational, zero latency.
  - p_bypass=1: if any enabled write targets read_addr[k] this cycle, read_data[k] = that write data (write1 has priority over write0) and read_busy[k] = 0.
  - p_bypass=0: read_data[k] is the stored value and read_busy[k] is the registered busy bit.
- Allocate, on the rising edge: busy[alloc_addr] <= 1.
  - Allocate and write to the same address in the same cycle: data is written and busy ends at 1 (allocate wins).
  - Allocating an entry that is already busy and not being written that cycle sets err.
- p_zero_reg=1:
  - Writes and allocates to entry 0 are ignored; read of address 0 returns 0 with busy 0, bypass included.
  - num_busy never counts entry 0.
- num_busy is a registered counter.
  - Next value = current + (1 if an effective allocate sets a previously clear bit) − (number of distinct busy entries cleared by writes, excluding the allocated address).
  - Must always equal the popcount of busy. Never wraps: maximum is p_num_entries.
- err is set, and held until reset, on any of:
  - any enable X;
  - an enabled address X or >= p_num_entries;
  - an allocate to an already-busy entry.
- Out-of-range writes and allocates have no effect on state.
- Assertions, active when not in reset: VC_ASSERT_NOT_X on the enables, and on the addresses when enabled; VC_ASSERT for address < p_num_entries.
- Reset asserted mid-operation: state clears without waiting for a clock edge. The first edge after reset deasserts processes inputs normally.

Test Plan:
- Reset then read all addresses on both ports -> read_data=0, read_busy=0, num_busy=0, err=0.
- write0 addr 5 = 0xDEADBEEF with read_addr0=5 in the same cycle, p_bypass=1 -> read_data0=0xDEADBEEF immediately. Repeat with p_bypass=0 -> old value 0 that cycle, 0xDEADBEEF on the next.
- Both write ports to addr 7 (0x11 on port 0, 0x22 on port 1) -> entry 7 = 0x22. Write to addr 0 of 0xFF with p_zero_reg=1 -> reads 0.
- Allocate 3, 4, 9 on successive cycles -> num_busy 1, 2, 3 and read_busy set. Then write 4 while allocating 4 -> busy[4]=1, num_busy stays 3. Then write 3 and 9 on the two ports in one cycle -> num_busy=1.
- Allocate 3 twice without an intervening write -> err=1 and stays 1. Then assert reset asynchronously between edges -> err, busy and num_busy go to 0 before the next edge.
- Random stress, 10k cycles, against a reference model -> data, busy, num_busy and err match every cycle, and num_busy equals popcount(busy).

Source files
------------

// File: rtl/sm_regfile_nr2w_sb_if.sv
// sm_regfile_nr2w_sb_if: read, write, allocate and status bundle of the regfile.
// master = issue/writeback side driving requests, slave = the register file.
interface sm_regfile_nr2w_sb_if #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 32,
    parameter int p_num_rports  = 2,
    localparam int c_addr_nbits = $clog2(p_num_entries)
);
    logic [p_num_rports*c_addr_nbits-1:0] read_addr;
    logic [p_num_rports*p_data_nbits-1:0] read_data;
    logic [p_num_rports-1:0]              read_busy;

    logic                    write0_en;
    logic [c_addr_nbits-1:0] write0_addr;
    logic [p_data_nbits-1:0] write0_data;

    logic                    write1_en;
    logic [c_addr_nbits-1:0] write1_addr;
    logic [p_data_nbits-1:0] write1_data;

    logic                    alloc_en;
    logic [c_addr_nbits-1:0] alloc_addr;

    logic [c_addr_nbits:0]   num_busy;
    logic                    err;

    modport master (
        output read_addr,
        output write0_en, write0_addr, write0_data,
        output write1_en, write1_addr, write1_data,
        output alloc_en, alloc_addr,
        input  read_data, read_busy, num_busy, err
    );

    modport slave (
        input  read_addr,
        input  write0_en, write0_addr, write0_data,
        input  write1_en, write1_addr, write1_data,
        input  alloc_en, alloc_addr,
        output read_data, read_busy, num_busy, err
    );
endinterface

// File: rtl/sm_regfile_nr2w_sb.sv
// sm_regfile_nr2w_sb: N-read / 2-write register file with busy scoreboard.
// Ports: clk, reset (async, high), bus (slave): reads, write0/1, alloc, num_busy, err.
module sm_regfile_nr2w_sb #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 32,
    parameter int p_num_rports  = 2,
    parameter logic [p_data_nbits-1:0] p_reset_value = '0,
    parameter int p_zero_reg    = 1,
    parameter int p_bypass      = 1,
    localparam int c_addr_nbits = $clog2(p_num_entries)
) (
    input logic clk,
    input logic reset,
    sm_regfile_nr2w_sb_if.slave bus
);

    localparam int c_cnt_nbits = c_addr_nbits + 1;

    typedef logic [c_addr_nbits-1:0] addr_t;
    typedef logic [p_data_nbits-1:0] data_t;
    typedef logic [c_cnt_nbits-1:0]  cnt_t;

    data_t                    mem [p_num_entries];
    logic [p_num_entries-1:0] busy;
    cnt_t                     cnt;
    logic                     err_q;

    // Widened compare so a power-of-two depth does not fold to a constant.
    function automatic logic in_range(input addr_t a);
        return {1'b0, a} < cnt_t'(p_num_entries);
    endfunction

    function automatic logic is_zero(input addr_t a);
        return (p_zero_reg != 0) && (a == '0);
    endfunction

    // Qualified requests: enabled, in range, not the hardwired zero entry.
    // Written as if-chains so an unknown enable resolves to "no action".
    logic w0_act;
    logic w1_act;
    logic al_act;

    always_comb begin
        w0_act = 1'b0;
        w1_act = 1'b0;
        al_act = 1'b0;
        if (bus.write0_en && in_range(bus.write0_addr)
            && !is_zero(bus.write0_addr))
            w0_act = 1'b1;
        if (bus.write1_en && in_range(bus.write1_addr)
            && !is_zero(bus.write1_addr))
            w1_act = 1'b1;
        if (bus.alloc_en && in_range(bus.alloc_addr)
            && !is_zero(bus.alloc_addr))
            al_act = 1'b1;
    end

    // Scoreboard update vectors.
    logic [p_num_entries-1:0] clr_vec;
    logic [p_num_entries-1:0] set_vec;
    logic [p_num_entries-1:0] busy_nxt;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (w0_act) clr_vec[bus.write0_addr] = 1'b1;
        if (w1_act) clr_vec[bus.write1_addr] = 1'b1;
        if (al_act) set_vec[bus.alloc_addr] = 1'b1;
        busy_nxt = (busy & ~clr_vec) | set_vec;
    end

    // Counter delta. A write pair to one address clears only once, and
    // an allocate to the written address keeps the entry busy.
    logic same_w;
    logic w0_hits_al;
    logic w1_hits_al;
    logic inc;
    logic dec0;
    logic dec1;
    cnt_t cnt_nxt;

    always_comb begin
        same_w     = w0_act && w1_act
                     && (bus.write0_addr == bus.write1_addr);
        w0_hits_al = al_act && w0_act
                     && (bus.write0_addr == bus.alloc_addr);
        w1_hits_al = al_act && w1_act
                     && (bus.write1_addr == bus.alloc_addr);
        inc  = al_act && !busy[bus.alloc_addr];
        dec0 = w0_act && busy[bus.write0_addr]
               && !w0_hits_al && !same_w;
        dec1 = w1_act && busy[bus.write1_addr] && !w1_hits_al;
        cnt_nxt = cnt + cnt_t'(inc) - cnt_t'(dec0) - cnt_t'(dec1);
    end

    // Protocol error detection.
    logic err_set;

    always_comb begin
        err_set = 1'b0;
        if ($isunknown(bus.write0_en) || $isunknown(bus.write1_en)
            || $isunknown(bus.alloc_en))
            err_set = 1'b1;
        if (bus.write0_en && ($isunknown(bus.write0_addr)
            || !in_range(bus.write0_addr)))
            err_set = 1'b1;
        if (bus.write1_en && ($isunknown(bus.write1_addr)
            || !in_range(bus.write1_addr)))
            err_set = 1'b1;
        if (bus.alloc_en && ($isunknown(bus.alloc_addr)
            || !in_range(bus.alloc_addr)))
            err_set = 1'b1;
        if (al_act && busy[bus.alloc_addr]
            && !w0_hits_al && !w1_hits_al)
            err_set = 1'b1;
    end

    // State. write1 is issued last so it wins a same-address pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_num_entries; i++) begin
                if ((p_zero_reg != 0) && (i == 0))
                    mem[i] <= '0;
                else
                    mem[i] <= p_reset_value;
            end
            busy  <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (w0_act) mem[bus.write0_addr] <= bus.write0_data;
            if (w1_act) mem[bus.write1_addr] <= bus.write1_data;
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
            if (err_set) err_q <= 1'b1;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        addr_t ra;
        data_t rd;
        logic  rb;
        bus.read_data = '0;
        bus.read_busy = '0;
        for (int k = 0; k < p_num_rports; k++) begin
            ra = bus.read_addr[k*c_addr_nbits +: c_addr_nbits];
            rd = '0;
            rb = 1'b0;
            if (is_zero(ra) || !in_range(ra)) begin
                rd = '0;
                rb = 1'b0;
            end else if ((p_bypass != 0) && w1_act
                         && (bus.write1_addr == ra)) begin
                rd = bus.write1_data;
            end else if ((p_bypass != 0) && w0_act
                         && (bus.write0_addr == ra)) begin
                rd = bus.write0_data;
            end else begin
                rd = mem[ra];
                rb = busy[ra];
            end
            bus.read_data[k*p_data_nbits +: p_data_nbits] = rd;
            bus.read_busy[k] = rb;
        end
    end

    assign bus.num_busy = cnt;
    assign bus.err      = err_q;

    // Simulation-only protocol checks; ignored by synthesis.
    always @(posedge clk) begin
        if (!reset) begin
            a_w0_en_x: assert (!$isunknown(bus.write0_en));
            a_w1_en_x: assert (!$isunknown(bus.write1_en));
            a_al_en_x: assert (!$isunknown(bus.alloc_en));
            if (bus.write0_en) begin
                a_w0_addr_x: assert (!$isunknown(bus.write0_addr));
                a_w0_addr_r: assert (in_range(bus.write0_addr));
            end
            if (bus.write1_en) begin
                a_w1_addr_x: assert (!$isunknown(bus.write1_addr));
                a_w1_addr_r: assert (in_range(bus.write1_addr));
            end
            if (bus.alloc_en) begin
                a_al_addr_x: assert (!$isunknown(bus.alloc_addr));
                a_al_addr_r: assert (in_range(bus.alloc_addr));
            end
        end
    end

endmodule

// File: tb/tb_sm_regfile_nr2w_sb.sv
// tb_sm_regfile_nr2w_sb: directed and random checks of the scoreboarded regfile.
// Two instances (bypass on/off) share stimulus; a behavioural model predicts outputs.
module tb_sm_regfile_nr2w_sb;

    localparam int W  = 32;
    localparam int N  = 32;
    localparam int R  = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [R*AW-1:0] ra;
    logic            w0_en, w1_en, al_en;
    logic [AW-1:0]   w0_a, w1_a, al_a;
    logic [W-1:0]    w0_d, w1_d;

    sm_regfile_nr2w_sb_if #(
        .p_data_nbits(W), .p_num_entries(N), .p_num_rports(R)
    ) bus_b ();
    sm_regfile_nr2w_sb_if #(
        .p_data_nbits(W), .p_num_entries(N), .p_num_rports(R)
    ) bus_n ();

    assign bus_b.read_addr   = ra;
    assign bus_b.write0_en   = w0_en;
    assign bus_b.write0_addr = w0_a;
    assign bus_b.write0_data = w0_d;
    assign bus_b.write1_en   = w1_en;
    assign bus_b.write1_addr = w1_a;
    assign bus_b.write1_data = w1_d;
    assign bus_b.alloc_en    = al_en;
    assign bus_b.alloc_addr  = al_a;

    assign bus_n.read_addr   = ra;
    assign bus_n.write0_en   = w0_en;
    assign bus_n.write0_addr = w0_a;
    assign bus_n.write0_data = w0_d;
    assign bus_n.write1_en   = w1_en;
    assign bus_n.write1_addr = w1_a;
    assign bus_n.write1_data = w1_d;
    assign bus_n.alloc_en    = al_en;
    assign bus_n.alloc_addr  = al_a;

    sm_regfile_nr2w_sb #(
        .p_data_nbits(W), .p_num_entries(N), .p_num_rports(R),
        .p_reset_value('0), .p_zero_reg(1), .p_bypass(1)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    sm_regfile_nr2w_sb #(
        .p_data_nbits(W), .p_num_entries(N), .p_num_rports(R),
        .p_reset_value('0), .p_zero_reg(1), .p_bypass(0)
    ) dut_n (.clk(clk), .reset(reset), .bus(bus_n.slave));

    int checks = 0;
    int failures = 0;

    // Reference model: plain arrays updated by the architectural rules.
    logic [W-1:0] m_mem [N];
    bit           m_busy [N];
    bit           m_err;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        bit wr [N];
        for (int i = 0; i < N; i++) wr[i] = 1'b0;
        if (w0_en && w0_a != 0) begin
            m_mem[w0_a] = w0_d;
            wr[w0_a] = 1'b1;
        end
        if (w1_en && w1_a != 0) begin
            m_mem[w1_a] = w1_d;
            wr[w1_a] = 1'b1;
        end
        if (al_en && al_a != 0 && m_busy[al_a] && !wr[al_a])
            m_err = 1'b1;
        for (int i = 0; i < N; i++)
            if (wr[i]) m_busy[i] = 1'b0;
        if (al_en && al_a != 0) m_busy[al_a] = 1'b1;
    endtask

    function automatic int popcount();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [W:0] exp_rd(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && w1_en && int'(w1_a) == a) return {1'b0, w1_d};
        if (byp && w0_en && int'(w0_a) == a) return {1'b0, w0_d};
        return {m_busy[a], m_mem[a]};
    endfunction

    function automatic logic [W-1:0] rd_b(input int k);
        return bus_b.read_data[k*W +: W];
    endfunction

    function automatic logic [W-1:0] rd_n(input int k);
        return bus_n.read_data[k*W +: W];
    endfunction

    task automatic check_all();
        logic [W:0] e;
        int a;
        for (int k = 0; k < R; k++) begin
            a = int'(ra[k*AW +: AW]);
            e = exp_rd(a, 1'b1);
            chk($sformatf("b_rd%0d_a%0d", k, a), rd_b(k), e[W-1:0]);
            chk($sformatf("b_busy%0d_a%0d", k, a),
                W'(bus_b.read_busy[k]), W'(e[W]));
            e = exp_rd(a, 1'b0);
            chk($sformatf("n_rd%0d_a%0d", k, a), rd_n(k), e[W-1:0]);
            chk($sformatf("n_busy%0d_a%0d", k, a),
                W'(bus_n.read_busy[k]), W'(e[W]));
        end
        chk("num_busy", W'(bus_b.num_busy), W'(popcount()));
        chk("num_busy_n", W'(bus_n.num_busy), W'(popcount()));
        chk("err", W'(bus_b.err), W'(m_err));
        chk("err_n", W'(bus_n.err), W'(m_err));
    endtask

    task automatic idle();
        ra = '0;
        w0_en = 1'b0; w0_a = '0; w0_d = '0;
        w1_en = 1'b0; w1_a = '0; w1_d = '0;
        al_en = 1'b0; al_a = '0;
    endtask

    task automatic to_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Called at posedge+1: pulses reset between edges.
    task automatic mid_reset();
        idle();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("mr_err", W'(bus_b.err), '0);
        chk("mr_nb", W'(bus_b.num_busy), '0);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        model_reset();
        #12;
        for (int a = 0; a < N; a++) begin
            ra = {AW'(a), AW'(N - 1 - a)};
            #1;
            check_all();
        end
        chk("rst_err", W'(bus_b.err), '0);
        chk("rst_nb", W'(bus_b.num_busy), '0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Bypass vs. registered read of a fresh write.
        idle();
        w0_en = 1'b1; w0_a = 5; w0_d = 32'hDEADBEEF;
        ra[0 +: AW] = 5;
        to_neg();
        chk("byp_rd5", rd_b(0), 32'hDEADBEEF);
        chk("nobyp_rd5", rd_n(0), 32'h0);
        to_pos();
        idle();
        ra[0 +: AW] = 5;
        to_neg();
        chk("nobyp_rd5_next", rd_n(0), 32'hDEADBEEF);
        to_pos();

        // Same-address write pair, then write to zero entry.
        idle();
        w0_en = 1'b1; w0_a = 7; w0_d = 32'h11;
        w1_en = 1'b1; w1_a = 7; w1_d = 32'h22;
        to_neg();
        chk("pair_byp7", rd_b(0), 32'h0);
        to_pos();
        idle();
        ra[0 +: AW] = 7;
        ra[AW +: AW] = 0;
        w0_en = 1'b1; w0_a = 0; w0_d = 32'hFF;
        to_neg();
        chk("pair_rd7", rd_n(0), 32'h22);
        chk("zero_byp", rd_b(1), 32'h0);
        to_pos();
        idle();
        to_neg();
        chk("zero_rd", rd_n(1), 32'h0);
        to_pos();

        // Scoreboard counting.
        idle(); al_en = 1'b1; al_a = 3;
        to_neg(); to_pos();
        idle(); al_en = 1'b1; al_a = 4;
        to_neg();
        chk("nb_1", W'(bus_b.num_busy), 1);
        to_pos();
        idle(); al_en = 1'b1; al_a = 9;
        to_neg();
        chk("nb_2", W'(bus_b.num_busy), 2);
        to_pos();
        idle();
        ra[0 +: AW] = 9;
        w0_en = 1'b1; w0_a = 4; w0_d = 32'h44;
        al_en = 1'b1; al_a = 4;
        to_neg();
        chk("nb_3", W'(bus_b.num_busy), 3);
        chk("busy9", W'(bus_n.read_busy[0]), 1);
        to_pos();
        idle();
        ra[0 +: AW] = 4;
        w0_en = 1'b1; w0_a = 3; w0_d = 32'h33;
        w1_en = 1'b1; w1_a = 9; w1_d = 32'h99;
        to_neg();
        chk("busy4_alloc_wins", W'(bus_b.read_busy[0]), 1);
        chk("nb_3_hold", W'(bus_b.num_busy), 3);
        to_pos();
        idle();
        to_neg();
        chk("nb_after_wb", W'(bus_b.num_busy), 1);
        to_pos();

        // Double allocate sets a sticky error.
        idle(); al_en = 1'b1; al_a = 3;
        to_neg(); to_pos();
        to_neg();
        chk("err_pre", W'(bus_b.err), 0);
        to_pos();
        idle();
        to_neg();
        chk("err_set", W'(bus_b.err), 1);
        to_pos();
        to_neg();
        chk("err_sticky", W'(bus_b.err), 1);
        chk("nb_2b", W'(bus_b.num_busy), 2);
        to_pos();
        mid_reset();
        to_neg();
        to_pos();

        // Random stress.
        for (int i = 0; i < 10000; i++) begin
            w0_en = ($urandom_range(0, 9) < 4);
            w0_a  = AW'($urandom_range(0, N - 1));
            w0_d  = $urandom();
            w1_en = ($urandom_range(0, 9) < 4);
            w1_a  = ($urandom_range(0, 7) == 0) ? w0_a
                    : AW'($urandom_range(0, N - 1));
            w1_d  = $urandom();
            al_en = ($urandom_range(0, 9) < 3);
            al_a  = ($urandom_range(0, 5) == 0) ? w1_a
                    : AW'($urandom_range(0, N - 1));
            for (int k = 0; k < R; k++) begin
                case ($urandom_range(0, 3))
                    0: ra[k*AW +: AW] = w0_a;
                    1: ra[k*AW +: AW] = w1_a;
                    default: ra[k*AW +: AW] = AW'($urandom_range(0, N - 1));
                endcase
            end
            if (i % 2500 == 1234) mid_reset();
            to_neg();
            to_pos();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
